gshare_branch_predictor: RTL and testbench

//  Dynamic branch predictor in the IF stage of the 5-stage pipeline; replaces the static pc+4 predictor.

---
 rtl/gshare_branch_predictor.sv | 100 ++++++++++
 tb/tb_gshare_branch_predictor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
//   Next-fetch-PC predictor for the IF stage. A direct-mapped, tagged BTB
//   supplies the target. A gshare PHT of 2-bit saturating counters, indexed by
//   pc xor global history, supplies the direction. The prediction is purely
//   combinational and reads only registered state. EX-stage updates take
//   effect from the next cycle.
//
// Ports
//   clk             in   clock, all state changes on the rising edge
//   reset           in   synchronous active-high reset
//   current_pc      in   PC being fetched this cycle
//   pred_pc         out  predicted next fetch PC
//   pred_taken      out  BTB hit and PHT counter predicts taken
//   pred_pht_idx    out  PHT index used for this prediction (travels to EX)
//   update_valid    in   EX resolved a non-squashed control-flow instruction
//   update_pc       in   PC of the resolved instruction
//   update_pht_idx  in   pred_pht_idx that travelled with that instruction
//   update_taken    in   resolved direction
//   update_target   in   resolved taken target
module gshare_branch_predictor #(
  parameter int BTB_IDX_BITS = 5,
  parameter int BHR_BITS     = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         current_pc,
  output logic [31:0]         pred_pc,
  output logic                pred_taken,
  output logic [BHR_BITS-1:0] pred_pht_idx,
  input  logic                update_valid,
  input  logic [31:0]         update_pc,
  input  logic [BHR_BITS-1:0] update_pht_idx,
  input  logic                update_taken,
  input  logic [31:0]         update_target
);

  localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
  localparam int PHT_ENTRIES = 1 << BHR_BITS;
  localparam int TAG_BITS    = 32 - BTB_IDX_BITS - 2;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_BITS-1:0]    btb_tag    [BTB_ENTRIES];
  logic [31:0]            btb_target [BTB_ENTRIES];
  logic [1:0]             pht        [PHT_ENTRIES];
  logic [BHR_BITS-1:0]    bhr;

  logic [BTB_IDX_BITS-1:0] pred_bi;
  logic [TAG_BITS-1:0]     pred_tag;
  logic                    pred_hit;
  logic [BTB_IDX_BITS-1:0] upd_bi;
  logic [TAG_BITS-1:0]     upd_tag;
  logic                    do_update;

  // Instruction-alignment bits never take part in indexing or tagging.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{current_pc[1:0], update_pc[1:0]};

  // ---------------- predict ----------------
  assign pred_bi  = current_pc[BTB_IDX_BITS+1:2];
  assign pred_tag = current_pc[31:BTB_IDX_BITS+2];

  always_comb begin
    pred_pht_idx = current_pc[BHR_BITS+1:2] ^ bhr;
    pred_hit     = btb_valid[pred_bi] && (btb_tag[pred_bi] == pred_tag);
    pred_taken   = pred_hit && pht[pred_pht_idx][1];
    pred_pc      = pred_taken ? btb_target[pred_bi] : (current_pc + 32'd4);
  end

  // ---------------- update ----------------
  assign upd_bi    = update_pc[BTB_IDX_BITS+1:2];
  assign upd_tag   = update_pc[31:BTB_IDX_BITS+2];
  assign do_update = update_valid && !reset;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
  endfunction

  // Valid bits, counters and history carry the trained state and are reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid <= '0;
      bhr       <= '0;
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
    end else if (update_valid) begin
      pht[update_pht_idx] <= ctr_next(pht[update_pht_idx], update_taken);
      bhr                 <= {bhr[BHR_BITS-2:0], update_taken};
      if (update_taken) btb_valid[upd_bi] <= 1'b1;
    end
  end

  // Tags and targets are qualified by btb_valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (do_update && update_taken) begin
      btb_tag[upd_bi]    <= upd_tag;
      btb_target[upd_bi] <= update_target;
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;

  logic        clk;
  logic        reset;
  logic [31:0] current_pc;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [4:0]  pred_pht_idx;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [4:0]  update_pht_idx;
  logic        update_taken;
  logic [31:0] update_target;

  int passed = 0;
  int total  = 0;

  gshare_branch_predictor #(.BTB_IDX_BITS(5), .BHR_BITS(5)) dut (
    .clk(clk), .reset(reset), .current_pc(current_pc),
    .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_pht_idx(pred_pht_idx),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_pht_idx(update_pht_idx), .update_taken(update_taken),
    .update_target(update_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 32-entry tables addressed with plain arithmetic.
  bit          m_known = 0;
  bit          m_valid [32];
  logic [31:0] m_tag   [32];
  logic [31:0] m_tgt   [32];
  int          m_pht   [32];
  int          m_bhr;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 0;
      m_pht[i]   = 1;
    end
    m_bhr   = 0;
    m_known = 1;
  endtask

  task automatic model_update(input logic [31:0] upc, input logic [4:0] uidx,
                              input logic ut, input logic [31:0] utgt);
    int bi;
    bi = int'((upc >> 2) % 32);
    if (ut) begin
      if (m_pht[uidx] < 3) m_pht[uidx] = m_pht[uidx] + 1;
      m_valid[bi] = 1;
      m_tag[bi]   = upc >> 7;
      m_tgt[bi]   = utgt;
    end else begin
      if (m_pht[uidx] > 0) m_pht[uidx] = m_pht[uidx] - 1;
    end
    m_bhr = (m_bhr * 2 + (ut ? 1 : 0)) % 32;
  endtask

  task automatic model_predict(input logic [31:0] pc, output logic [31:0] epc,
                               output logic et, output logic [4:0] eidx);
    int bi;
    int idx;
    bi   = int'((pc >> 2) % 32);
    idx  = bi ^ m_bhr;
    eidx = 5'(idx);
    et   = m_valid[bi] && (m_tag[bi] == (pc >> 7)) && (m_pht[idx] >= 2);
    epc  = et ? m_tgt[bi] : pc + 32'd4;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Check the outputs for pc against explicit values, without clocking.
  task automatic expect_now(input string tag, input logic [31:0] pc,
                            input logic [31:0] epc, input logic et, input logic [4:0] eidx);
    reset      = 1'b0;
    current_pc = pc;
    #1;
    chk({tag, "_pc"},  pred_pc, epc);
    chk({tag, "_tk"},  {31'd0, pred_taken}, {31'd0, et});
    chk({tag, "_idx"}, {27'd0, pred_pht_idx}, {27'd0, eidx});
  endtask

  // One clock cycle: drive at negedge, check against the model, clock, advance the model.
  task automatic cyc(input logic rst, input logic [31:0] pc, input logic uv,
                     input logic [31:0] upc, input logic [4:0] uidx,
                     input logic ut, input logic [31:0] utgt);
    logic [31:0] epc;
    logic        et;
    logic [4:0]  eidx;
    reset          = rst;
    current_pc     = pc;
    update_valid   = uv;
    update_pc      = upc;
    update_pht_idx = uidx;
    update_taken   = ut;
    update_target  = utgt;
    #1;
    if (m_known) begin
      model_predict(pc, epc, et, eidx);
      chk("m_pc",  pred_pc, epc);
      chk("m_tk",  {31'd0, pred_taken}, {31'd0, et});
      chk("m_idx", {27'd0, pred_pht_idx}, {27'd0, eidx});
    end
    @(posedge clk);
    if (rst) model_reset();
    else if (uv) model_update(upc, uidx, ut, utgt);
    @(negedge clk);
    update_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rpc, rupc, rtgt;
    reset = 1'b1; current_pc = 32'h40; update_valid = 1'b0;
    update_pc = '0; update_pht_idx = '0; update_taken = 1'b0; update_target = '0;
    @(negedge clk);
    cyc(1, 32'h40, 0, 0, 0, 0, 0);
    cyc(1, 32'h40, 1, 32'h40, 5'h10, 1, 32'h20);

    // reset state, including 32-bit wrap of pc+4
    expect_now("t1", 32'h40, 32'h44, 1'b0, 5'h10);
    expect_now("wrap", 32'hFFFF_FFFC, 32'h0, 1'b0, 5'h1F);

    // first training: same-cycle query sees pre-update state
    update_valid = 1; update_pc = 32'h40; update_pht_idx = 5'h10;
    update_taken = 1; update_target = 32'h20;
    expect_now("t5_same", 32'h40, 32'h44, 1'b0, 5'h10);
    cyc(0, 32'h40, 1, 32'h40, 5'h10, 1, 32'h20);
    expect_now("t2_next", 32'h40, 32'h44, 1'b0, 5'h11);

    // saturate high, one not-taken, then clear history with not-taken updates
    repeat (4) cyc(0, 32'h80, 1, 32'h40, 5'h10, 1, 32'h20);
    cyc(0, 32'h80, 1, 32'h40, 5'h10, 0, 32'h20);
    repeat (5) cyc(0, 32'h80, 1, 32'h0, 5'h00, 0, 32'h0);
    expect_now("t3", 32'h40, 32'h20, 1'b1, 5'h10);

    // same BTB index, different tag
    expect_now("t4_alias", 32'h840, 32'h844, 1'b0, 5'h10);

    // retarget in the same cycle as a query of that entry
    update_valid = 1; update_pc = 32'h40; update_pht_idx = 5'h10;
    update_taken = 1; update_target = 32'h100;
    expect_now("t5b_same", 32'h40, 32'h20, 1'b1, 5'h10);
    cyc(0, 32'h40, 1, 32'h40, 5'h10, 1, 32'h100);
    repeat (5) cyc(0, 32'h80, 1, 32'h0, 5'h01, 0, 32'h0);
    expect_now("t5b_next", 32'h40, 32'h100, 1'b1, 5'h10);

    // stall: held PC, no update, no change
    repeat (3) cyc(0, 32'h40, 0, 0, 0, 0, 0);
    expect_now("stall", 32'h40, 32'h100, 1'b1, 5'h10);

    // aliasing entry overwrites the previous owner
    cyc(0, 32'h80, 1, 32'h840, 5'h10, 1, 32'h300);
    repeat (5) cyc(0, 32'h80, 1, 32'h0, 5'h02, 0, 32'h0);
    expect_now("alias_new", 32'h840, 32'h300, 1'b1, 5'h10);
    expect_now("alias_old", 32'h40, 32'h44, 1'b0, 5'h10);

    // one-cycle reset mid-stream discards training
    cyc(1, 32'h40, 0, 0, 0, 0, 0);
    expect_now("t6", 32'h40, 32'h44, 1'b0, 5'h10);

    // randomized traffic on a small tag space to provoke aliasing
    for (int n = 0; n < 3000; n++) begin
      rpc  = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2);
      if ($urandom_range(0, 49) == 0) rpc = 32'hFFFF_FFFC;
      rupc = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 31) << 2);
      rtgt = $urandom & 32'hFFFF_FFFC;
      cyc(($urandom_range(0, 299) == 0), rpc, ($urandom_range(0, 2) != 0), rupc,
          5'($urandom_range(0, 31)), ($urandom_range(0, 2) != 0), rtgt);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
